// File: rtl/cl_pcim_wr_sched.sv
// PCIM write-burst scheduler: buffers 512b stream beats and carves them into aligned INCR
// bursts written into a host ring buffer, tracking outstanding AWs and B responses.
module cl_pcim_wr_sched #(
  parameter int BURST_BEATS     = 16,
  parameter int FIFO_DEPTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYC     = 256
) (
  input  logic         clk_main_a0,
  input  logic         rst_main,
  input  logic         cfg_enable,
  input  logic [63:0]  cfg_base_addr,
  input  logic [31:0]  cfg_ring_beats,
  input  logic         cfg_flush,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [511:0] s_axis_tdata,
  output logic [15:0]  m_axi_awid,
  output logic [63:0]  m_axi_awaddr,
  output logic [7:0]   m_axi_awlen,
  output logic [2:0]   m_axi_awsize,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [511:0] m_axi_wdata,
  output logic [63:0]  m_axi_wstrb,
  output logic         m_axi_wlast,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  input  logic [15:0]  m_axi_bid,
  input  logic [1:0]   m_axi_bresp,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready,
  output logic         sts_busy,
  output logic [31:0]  sts_wr_ptr,
  output logic [31:0]  sts_beats_acked,
  output logic [3:0]   sts_outstanding,
  output logic         sts_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W} state_t;

  state_t        state, state_nx;
  logic [511:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] fifo_wr, fifo_rd;
  logic [PW:0]   fifo_cnt;
  logic          enable_q;
  logic [63:0]   base_q;
  logic [31:0]   ring_q, wr_ptr, idle_cnt;
  logic          flush_pend;
  logic [7:0]    burst_n, beat_cnt;
  logic [63:0]   aw_addr_q;
  logic [3:0]    outstanding;
  logic [31:0]   beats_acked;
  logic          err;
  logic [7:0]    nq [MAX_OUTSTANDING];
  logic [QW-1:0] nq_wr, nq_rd;

  logic        accept, pop, aw_fire, b_fire, enable_rise, timeout, launch_ok, launch, wlast;
  logic [31:0] occ, bnd, n_next;
  logic        bid_unused;

  assign bid_unused    = ^m_axi_bid;
  assign s_axis_tready = (fifo_cnt != (PW+1)'(FIFO_DEPTH));
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign pop           = m_axi_wvalid & m_axi_wready;
  assign aw_fire       = m_axi_awvalid & m_axi_awready;
  assign b_fire        = m_axi_bvalid & (outstanding != 4'd0);
  assign enable_rise   = cfg_enable & ~enable_q;

  // A burst never straddles a BURST_BEATS-aligned ring offset, so it cannot cross 4KB or the ring end.
  assign occ       = 32'(fifo_cnt);
  assign bnd       = 32'(BURST_BEATS) - (wr_ptr % 32'(BURST_BEATS));
  assign n_next    = (occ < bnd) ? occ : bnd;
  assign timeout   = (TIMEOUT_CYC != 0) && (idle_cnt >= 32'(TIMEOUT_CYC));
  assign launch_ok = cfg_enable & enable_q & (outstanding < 4'(MAX_OUTSTANDING)) &
                     ((occ >= bnd) | ((occ != 32'd0) & (flush_pend | timeout)));
  assign wlast     = (beat_cnt == burst_n - 8'd1);

  always_comb begin
    state_nx      = state;
    launch        = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    unique case (state)
      ST_IDLE: if (launch_ok) begin
        launch   = 1'b1;
        state_nx = ST_AW;
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nx = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = (fifo_cnt != '0);
        if (m_axi_wvalid && m_axi_wready && wlast) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0) begin
    if (accept) mem[fifo_wr] <= s_axis_tdata;
    if (aw_fire) nq[nq_wr] <= burst_n;
  end

  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      state       <= ST_IDLE;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      fifo_cnt    <= '0;
      enable_q    <= 1'b0;
      base_q      <= '0;
      ring_q      <= '0;
      wr_ptr      <= '0;
      idle_cnt    <= '0;
      flush_pend  <= 1'b0;
      burst_n     <= '0;
      beat_cnt    <= '0;
      aw_addr_q   <= '0;
      outstanding <= '0;
      beats_acked <= '0;
      err         <= 1'b0;
      nq_wr       <= '0;
      nq_rd       <= '0;
    end else begin
      state    <= state_nx;
      enable_q <= cfg_enable;
      if (accept) fifo_wr <= fifo_wr + 1'b1;
      if (pop) fifo_rd <= fifo_rd + 1'b1;
      fifo_cnt <= fifo_cnt + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop};

      if (enable_rise) begin
        base_q <= cfg_base_addr;
        ring_q <= cfg_ring_beats;
      end
      if (enable_rise) wr_ptr <= '0;
      else if (aw_fire) wr_ptr <= (wr_ptr + 32'(burst_n) == ring_q) ? 32'd0 : wr_ptr + 32'(burst_n);

      if (accept || launch || fifo_cnt == '0) idle_cnt <= '0;
      else if (idle_cnt < 32'(TIMEOUT_CYC)) idle_cnt <= idle_cnt + 32'd1;

      // A flush request arriving on a launch cycle survives so it still covers data left behind.
      if (cfg_flush) flush_pend <= 1'b1;
      else if (launch) flush_pend <= 1'b0;

      if (launch) begin
        burst_n   <= 8'(n_next);
        beat_cnt  <= '0;
        aw_addr_q <= base_q + {26'd0, wr_ptr, 6'd0};
      end else if (pop) begin
        beat_cnt <= beat_cnt + 8'd1;
      end

      unique case ({aw_fire, b_fire})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
      if (aw_fire) nq_wr <= (nq_wr == QW'(MAX_OUTSTANDING - 1)) ? '0 : nq_wr + 1'b1;
      if (b_fire) begin
        nq_rd       <= (nq_rd == QW'(MAX_OUTSTANDING - 1)) ? '0 : nq_rd + 1'b1;
        beats_acked <= beats_acked + 32'(nq[nq_rd]);
      end

      if (!cfg_enable) err <= 1'b0;
      else if (b_fire && m_axi_bresp != 2'b00) err <= 1'b1;
    end
  end

  ring_cfg_legal: assert property (@(posedge clk_main_a0) disable iff (rst_main)
    enable_rise |-> (cfg_ring_beats != 32'd0 && (cfg_ring_beats % 32'(BURST_BEATS)) == 32'd0));

  assign m_axi_awid      = 16'h0;
  assign m_axi_awaddr    = aw_addr_q;
  assign m_axi_awlen     = burst_n - 8'd1;
  assign m_axi_awsize    = 3'h6;
  assign m_axi_wdata     = mem[fifo_rd];
  assign m_axi_wstrb     = {64{1'b1}};
  assign m_axi_wlast     = wlast & (state == ST_W);
  assign m_axi_bready    = 1'b1;
  assign sts_busy        = (fifo_cnt != '0) | (state != ST_IDLE) | (outstanding != 4'd0);
  assign sts_wr_ptr      = wr_ptr;
  assign sts_beats_acked = beats_acked;
  assign sts_outstanding = outstanding;
  assign sts_err         = err;

endmodule
